// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_pkg
//  Purpose  : Shared constants and helpers for the TMDS 8b/10b encoder:
//             control tokens, TERC4 code table, disparity counter width and
//             an 8-bit population count.
//  Config   : TMDS_TERC4_EN (terc4_code is only referenced when defined)
//  Revision : 1.0  initial release
// ============================================================================
package tmds_pkg;

  // Width of the signed running-disparity counter (range -8..+8).
  localparam int CNT_W = 5;

  // Control tokens indexed by {c1, c0}.
  localparam logic [3:0][9:0] CTRL_TOKEN = {10'h2AB, 10'h154, 10'h0AB, 10'h354};

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [9:0] terc4_code(input logic [3:0] nib);
    logic [9:0] code;
    case (nib)
      4'h0:    code = 10'h29C;
      4'h1:    code = 10'h263;
      4'h2:    code = 10'h2E4;
      4'h3:    code = 10'h2E2;
      4'h4:    code = 10'h171;
      4'h5:    code = 10'h11E;
      4'h6:    code = 10'h18E;
      4'h7:    code = 10'h13C;
      4'h8:    code = 10'h2CC;
      4'h9:    code = 10'h139;
      4'hA:    code = 10'h19C;
      4'hB:    code = 10'h2C6;
      4'hC:    code = 10'h28E;
      4'hD:    code = 10'h271;
      4'hE:    code = 10'h163;
      default: code = 10'h2C3;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_qm_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_qm_stage
//  Purpose  : First two pipeline stages of the TMDS encoder. Stage 1 registers
//             the inputs together with the ones count of din; stage 2 builds
//             the transition-minimised word q_m[8:0] and registers it with
//             its ones/zeros counts and the delayed control fields.
//  Ports    : gclk      in   pixel clock
//             reset     in   synchronous active-high reset
//             din[7:0]  in   pixel byte
//             c0, c1    in   control bits
//             de        in   active-video flag
//             aux[3:0]  in   TERC4 nibble        (TMDS_TERC4_EN only)
//             island    in   data-island flag    (TMDS_TERC4_EN only)
//             aux_q     out  delayed aux         (TMDS_TERC4_EN only)
//             island_q  out  delayed island      (TMDS_TERC4_EN only)
//             qm[8:0]   out  registered q_m
//             n1q, n0q  out  ones / zeros in qm[7:0]
//             de_q      out  delayed de
//             c_q[1:0]  out  delayed {c1, c0}
//  Config   : TMDS_TERC4_EN adds the aux/island path
//  Revision : 1.0  initial release
// ============================================================================
module tmds_qm_stage
  import tmds_pkg::*;
(
  input  logic       gclk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       c0,
  input  logic       c1,
  input  logic       de,
`ifdef TMDS_TERC4_EN
  input  logic [3:0] aux,
  input  logic       island,
  output logic [3:0] aux_q,
  output logic       island_q,
`endif
  output logic [8:0] qm,
  output logic [3:0] n1q,
  output logic [3:0] n0q,
  output logic       de_q,
  output logic [1:0] c_q
);

  // Stage 1 registers
  logic [7:0] r_din;
  logic [3:0] r_n1d;
  logic       r_de;
  logic [1:0] r_c;
`ifdef TMDS_TERC4_EN
  logic [3:0] r_aux;
  logic       r_island;
`endif

  logic       w_use_xnor;
  logic [8:0] w_qm;
  logic [3:0] w_n1q;

  always_ff @(posedge gclk) begin
    if (reset) begin
      r_din <= '0;
      r_n1d <= '0;
      r_de  <= 1'b0;
      r_c   <= '0;
    end else begin
      r_din <= din;
      r_n1d <= popcount8(din);
      r_de  <= de;
      r_c   <= {c1, c0};
    end
  end

  // XNOR is chosen for ones-heavy bytes to minimise transitions; the tie at
  // four ones is broken on din[0] so the choice is decodable from q_m[8].
  always_comb begin
    logic [7:0] t;
    w_use_xnor = (r_n1d > 4'd4) || ((r_n1d == 4'd4) && !r_din[0]);
    t    = '0;
    t[0] = r_din[0];
    for (int i = 1; i < 8; i++) begin
      t[i] = w_use_xnor ? ~(t[i-1] ^ r_din[i]) : (t[i-1] ^ r_din[i]);
    end
    w_qm  = {~w_use_xnor, t};
    w_n1q = popcount8(t);
  end

  always_ff @(posedge gclk) begin
    if (reset) begin
      qm   <= '0;
      n1q  <= '0;
      n0q  <= '0;
      de_q <= 1'b0;
      c_q  <= '0;
    end else begin
      qm   <= w_qm;
      n1q  <= w_n1q;
      n0q  <= 4'd8 - w_n1q;
      de_q <= r_de;
      c_q  <= r_c;
    end
  end

`ifdef TMDS_TERC4_EN
  always_ff @(posedge gclk) begin
    if (reset) begin
      r_aux    <= '0;
      r_island <= 1'b0;
      aux_q    <= '0;
      island_q <= 1'b0;
    end else begin
      r_aux    <= aux;
      r_island <= island;
      aux_q    <= r_aux;
      island_q <= r_island;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/tmds_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_encoder
//  Purpose  : DVI TMDS 8b/10b encoder for one colour channel. Three-stage
//             pipeline (inputs at edge k appear on dout at edge k+2) with a
//             running-disparity counter for DC balance and control tokens
//             during blanking.
//  Ports    : gclk       in   pixel clock
//             reset      in   synchronous active-high reset
//             din[7:0]   in   pixel byte, used when de=1
//             c0, c1     in   control bits (HSYNC/VSYNC on blue)
//             de         in   1 = active video, 0 = blanking
//             aux[3:0]   in   TERC4 nibble       (TMDS_TERC4_EN only)
//             island     in   data-island flag   (TMDS_TERC4_EN only)
//             dout[9:0]  out  TMDS code word, bit 0 sent first
//  Config   : TMDS_TERC4_EN enables data-island TERC4 encoding
//  Revision : 1.0  initial release
// ============================================================================
module tmds_encoder
  import tmds_pkg::*;
(
  input  logic       gclk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       c0,
  input  logic       c1,
  input  logic       de,
`ifdef TMDS_TERC4_EN
  input  logic [3:0] aux,
  input  logic       island,
`endif
  output logic [9:0] dout
);

  localparam logic signed [CNT_W-1:0] c_cnt_two = 5'sd2;

  logic [8:0] qm;
  logic [3:0] n1q;
  logic [3:0] n0q;
  logic       de_q;
  logic [1:0] c_q;
`ifdef TMDS_TERC4_EN
  logic [3:0] aux_q;
  logic       island_q;
`endif

  tmds_qm_stage u_qm_stage (
    .gclk     (gclk),
    .reset    (reset),
    .din      (din),
    .c0       (c0),
    .c1       (c1),
    .de       (de),
`ifdef TMDS_TERC4_EN
    .aux      (aux),
    .island   (island),
    .aux_q    (aux_q),
    .island_q (island_q),
`endif
    .qm       (qm),
    .n1q      (n1q),
    .n0q      (n0q),
    .de_q     (de_q),
    .c_q      (c_q)
  );

  logic signed [CNT_W-1:0] r_cnt;
  logic signed [CNT_W-1:0] w_cnt_nxt;
  logic signed [CNT_W-1:0] w_diff;
  logic signed [CNT_W-1:0] w_qm8_two;
  logic signed [CNT_W-1:0] w_nqm8_two;
  logic [9:0]              w_dout_nxt;

  // Counts are zero-extended to the signed counter width before subtraction,
  // so w_diff = n1q - n0q lies in -8..+8 without overflow.
  always_comb begin
    w_diff     = $signed({1'b0, n1q}) - $signed({1'b0, n0q});
    w_qm8_two  = qm[8] ? c_cnt_two : '0;
    w_nqm8_two = qm[8] ? '0 : c_cnt_two;
    w_dout_nxt = CTRL_TOKEN[c_q];
    w_cnt_nxt  = '0;
    if (de_q) begin
      if ((r_cnt == 0) || (n1q == n0q)) begin
        w_dout_nxt = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        w_cnt_nxt  = qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
      end else if (((r_cnt > 0) && (n1q > n0q)) || ((r_cnt < 0) && (n0q > n1q))) begin
        w_dout_nxt = {1'b1, qm[8], ~qm[7:0]};
        w_cnt_nxt  = r_cnt + w_qm8_two - w_diff;
      end else begin
        w_dout_nxt = {1'b0, qm[8], qm[7:0]};
        w_cnt_nxt  = r_cnt + w_diff - w_nqm8_two;
      end
    end
`ifdef TMDS_TERC4_EN
    else if (island_q) begin
      w_dout_nxt = terc4_code(aux_q);
    end
`endif
  end

  always_ff @(posedge gclk) begin
    if (reset) begin
      dout  <= '0;
      r_cnt <= '0;
    end else begin
      dout  <= w_dout_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule
`default_nettype wire
